// File: rtl/sra_iter_pkg.sv
// Shared definitions for the iterative right shifter: state encoding, stage count
// and the ALU shift opcodes that the decoder also uses.
package sra_iter_pkg;

    localparam int WIDTH        = 32;
    localparam int SHAMT_W      = 5;
    localparam int SHIFT_STAGES = SHAMT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Right-shift opcodes as seen by the ALU decode
    localparam logic [3:0] ALU_OP_SRL = 4'b0101;
    localparam logic [3:0] ALU_OP_SRA = 4'b1101;

    function automatic int cnt_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/sra_iter_if.sv
// Start/ready handshake bundle between the processor and the iterative shifter.
interface sra_iter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               ctrl_start;
    logic               ctrl_arith;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] shiftamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output ctrl_start, ctrl_arith, data_operandA, shiftamt,
        input  data_result, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_start, ctrl_arith, data_operandA, shiftamt,
        output data_result, data_resultRDY, busy
    );
endinterface

// File: rtl/sra_iter_stage.sv
// One log-stage of the right shifter: shifts acc by 2**cnt when en is set, filling
// the vacated MSBs with fill. Built as a per-stage wiring mux, no >>> operator.
module sra_stage
    import sra_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 3
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] shifted_o
);

    logic [SHAMT_W-1:0][WIDTH-1:0] stg;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam int SRC = i + (1 << k);
            if (SRC < WIDTH) begin : g_src
                assign stg[k][i] = acc_i[SRC];
            end else begin : g_fill
                assign stg[k][i] = fill_i;
            end
        end
    end

    always_comb begin
        shifted_o = acc_i;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (en_i && (cnt_i == CNT_W'(k))) begin
                shifted_o = stg[k];
            end
        end
    end

endmodule

// File: rtl/sra_iter.sv
// Iterative SRL/SRA unit: one log-stage per cycle, fixed SHAMT_W-cycle latency so the
// stall logic can treat it like multdiv.
module sra_iter
    import sra_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    sra_iter_if.slave  bus
);

    localparam int CNT_W = cnt_width(SHAMT_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               fill_q, fill_d;
    logic               stage_en;
    logic               last_stage;
    logic [WIDTH-1:0]   stage_out;

    // Select amt_q[cnt_q] without indexing past the amount width
    always_comb begin
        stage_en = 1'b0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                stage_en = amt_q[k];
            end
        end
    end

    assign last_stage = (cnt_q == CNT_W'(SHAMT_W - 1));

    sra_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .CNT_W   (CNT_W)
    ) u_stage (
        .acc_i     (acc_q),
        .cnt_i     (cnt_q),
        .en_i      (stage_en),
        .fill_i    (fill_q),
        .shifted_o (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        amt_d    = amt_q;
        fill_d   = fill_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.ctrl_start) begin
                    state_d = ST_SHIFT;
                    acc_d   = bus.data_operandA;
                    amt_d   = bus.shiftamt;
                    fill_d  = bus.ctrl_arith & bus.data_operandA[WIDTH-1];
                    cnt_d   = '0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = stage_out;
                cnt_d = cnt_q + 1'b1;
                if (last_stage) begin
                    state_d  = ST_DONE;
                    result_d = stage_out;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            amt_q    <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = (state_q == ST_DONE);
    assign bus.busy           = (state_q == ST_SHIFT);

endmodule
